// File: rtl/sa_gemm_sequencer.sv
// Purpose: sequences one weight-stationary GEMM job (weight load, skewed activation stream, drain, done).
// Latency: first issue 1 cycle after the last weight load; out_valid[i] trails its issue by SA_SIZE+i cycles.
// Backpressure: w_valid/act_valid low stalls the load/issue; bubbles travel the skew pipe as zeros.
// Option: define SA_SEQ_KEEP_WEIGHTS_EN to add keep_weights (reuse already loaded weights, skip LOAD_W).
module sa_gemm_sequencer #(
    parameter int SA_SIZE   = 3,
    parameter int ROW_CNT_W = 8,
    localparam int IDX_W    = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef SA_SEQ_KEEP_WEIGHTS_EN
    input  logic                 keep_weights,
`endif
    input  logic [ROW_CNT_W-1:0] num_rows,
    output logic                 busy,
    output logic                 done,
    input  logic                 w_valid,
    output logic                 w_ready,
    output logic [IDX_W-1:0]     w_row_idx,
    output logic [SA_SIZE-1:0]   sa_w_load,
    input  logic                 act_valid,
    output logic                 act_ready,
    output logic [SA_SIZE-1:0]   sa_act_en,
    output logic [SA_SIZE-1:0]   out_valid
);

    // Skew pipe taps: tap 0 is the live issue, taps 1..2*SA_SIZE-1 are registered delays.
    // The last tap feeds out_valid[SA_SIZE-1] and needs no register behind it.
    localparam int SH_W = 2 * SA_SIZE - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ROW_CNT_W-1:0]   r_num_rows;
    logic [ROW_CNT_W-1:0]   r_issue_cnt;
    logic [IDX_W-1:0]       r_w_idx;
    logic [SH_W-1:0]        r_skew;
    logic [SH_W:0]          w_taps;
    logic                   w_w_hs;
    logic                   w_issue;
    logic                   w_last_w;
    logic                   w_last_issue;
    logic                   w_pipe_empty;
    logic                   w_skip_load;

    assign w_w_hs       = w_valid && (r_state == S_LOAD_W);
    assign w_issue      = act_valid && (r_state == S_STREAM);
    assign w_last_w     = (r_w_idx == IDX_W'(SA_SIZE - 1));
    assign w_last_issue = (r_issue_cnt == (r_num_rows - ROW_CNT_W'(1)));
    // Only the final tap may still be set: it is consumed this cycle, so the pipe is empty next cycle.
    assign w_pipe_empty = (r_skew[SH_W-2:0] == '0);
    assign w_taps       = {r_skew, w_issue};

    assign w_row_idx = r_w_idx;
    assign sa_w_load = w_w_hs ? (SA_SIZE'(1) << r_w_idx) : '0;
    assign sa_act_en = w_taps[SA_SIZE-1:0];
    assign out_valid = w_taps[2*SA_SIZE-1:SA_SIZE];

`ifdef SA_SEQ_KEEP_WEIGHTS_EN
    logic r_weights_loaded;

    // Remember that the array holds a full weight set; only reset forgets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_weights_loaded <= 1'b0;
        end else if (w_w_hs && w_last_w) begin
            r_weights_loaded <= 1'b1;
        end
    end

    assign w_skip_load = keep_weights && r_weights_loaded;
`else
    assign w_skip_load = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs; handshakes are never open in two states at once.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        done      = 1'b0;
        w_ready   = 1'b0;
        act_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_skip_load) begin
                        w_next = (num_rows == '0) ? S_DRAIN : S_STREAM;
                    end else begin
                        w_next = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                w_ready = 1'b1;
                if (w_w_hs && w_last_w) begin
                    w_next = (r_num_rows == '0) ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                act_ready = 1'b1;
                if (w_issue && w_last_issue) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Job length capture, weight row index, issue counter and the issue skew pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_rows  <= '0;
            r_w_idx     <= '0;
            r_issue_cnt <= '0;
            r_skew      <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_num_rows <= num_rows;
            end
            if (w_w_hs) begin
                r_w_idx <= w_last_w ? '0 : r_w_idx + IDX_W'(1);
            end
            if (w_issue) begin
                r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + ROW_CNT_W'(1);
            end
            r_skew <= {r_skew[SH_W-2:0], w_issue};
        end
    end

endmodule

// File: tb/tb_sa_gemm_sequencer.sv
// Purpose: directed, table-driven check of sa_gemm_sequencer with SA_SIZE=3.
// Latency: each table job runs a fixed 16-cycle window starting at the start cycle.
// Backpressure: rows stall w_valid / act_valid for one chosen cycle each.
module tb_sa_gemm_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] num_rows = '0;
    logic       busy, done, w_ready, act_ready;
    logic       w_valid = 1'b1;
    logic       act_valid = 1'b1;
    logic [1:0] w_row_idx;
    logic [2:0] sa_w_load, sa_act_en, out_valid;
`ifdef SA_SEQ_KEEP_WEIGHTS_EN
    logic       keep_weights = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sa_gemm_sequencer #(.SA_SIZE(3), .ROW_CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SA_SEQ_KEEP_WEIGHTS_EN
        .keep_weights(keep_weights),
`endif
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_row_idx (w_row_idx),
        .sa_w_load (sa_w_load),
        .act_valid (act_valid),
        .act_ready (act_ready),
        .sa_act_en (sa_act_en),
        .out_valid (out_valid)
    );

    // One job: inputs plus per-cycle expected masks (bit c = signal high in cycle c).
    typedef struct {
        int          nr;
        int          w_low;
        int          a_low;
        int          ld0, ld1, ld2;
        logic [31:0] busy, done, wrdy, ardy;
        logic [31:0] en0, en1, en2, ov0, ov1, ov2;
    } vec_t;

    vec_t vecs[4];

    function automatic vec_t mk(input int nr, input int wl, input int al,
                                input int l0, input int l1, input int l2,
                                input logic [31:0] bz, input logic [31:0] dn,
                                input logic [31:0] wr, input logic [31:0] ar,
                                input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                                input logic [31:0] o0, input logic [31:0] o1, input logic [31:0] o2);
        vec_t v;
        v.nr = nr; v.w_low = wl; v.a_low = al;
        v.ld0 = l0; v.ld1 = l1; v.ld2 = l2;
        v.busy = bz; v.done = dn; v.wrdy = wr; v.ardy = ar;
        v.en0 = e0; v.en1 = e1; v.en2 = e2;
        v.ov0 = o0; v.ov1 = o1; v.ov2 = o2;
        return v;
    endfunction

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic run_job(input int k);
        vec_t v;
        logic [2:0] e_load;
        logic [1:0] e_idx;
        v = vecs[k];
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0);
            num_rows  = 8'(v.nr);
            w_valid   = (c != v.w_low);
            act_valid = (c != v.a_low);
            @(negedge clk);
            e_load = (c == v.ld0) ? 3'b001 : (c == v.ld1) ? 3'b010 : (c == v.ld2) ? 3'b100 : 3'b000;
            e_idx  = v.wrdy[c] ? 2'(int'(c > v.ld0) + int'(c > v.ld1)) : 2'd0;
            chk($sformatf("job%0d busy", k), c, busy, v.busy[c]);
            chk($sformatf("job%0d done", k), c, done, v.done[c]);
            chk($sformatf("job%0d w_ready", k), c, w_ready, v.wrdy[c]);
            chk($sformatf("job%0d act_ready", k), c, act_ready, v.ardy[c]);
            chk($sformatf("job%0d sa_w_load", k), c, sa_w_load, e_load);
            chk($sformatf("job%0d w_row_idx", k), c, w_row_idx, e_idx);
            chk($sformatf("job%0d sa_act_en", k), c, sa_act_en, {v.en2[c], v.en1[c], v.en0[c]});
            chk($sformatf("job%0d out_valid", k), c, out_valid, {v.ov2[c], v.ov1[c], v.ov0[c]});
        end
        w_valid   = 1'b1;
        act_valid = 1'b1;
    endtask

    initial begin
        // nr, w_low, a_low, loads, busy, done, w_ready, act_ready, en0..2, ov0..2
        vecs[0] = mk(2, -1, -1, 1, 2, 3, 32'hFFE, 32'h800, 32'hE, 32'h30,
                     32'h30, 32'h60, 32'hC0, 32'h180, 32'h300, 32'h600);
        vecs[1] = mk(2, 2, 5, 1, 3, 4, 32'h3FFE, 32'h2000, 32'h1E, 32'hE0,
                     32'hC0, 32'h180, 32'h300, 32'h600, 32'hC00, 32'h1800);
        vecs[2] = mk(0, -1, -1, 1, 2, 3, 32'h3E, 32'h20, 32'hE, 32'h0,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[3] = mk(1, 1, -1, 2, 3, 4, 32'hFFE, 32'h800, 32'h1E, 32'h20,
                     32'h20, 32'h40, 32'h80, 32'h100, 32'h200, 32'h400);

        // Reset state while rst is held.
        #2;
        chk("rst busy", 0, busy, 0);
        chk("rst done", 0, done, 0);
        chk("rst w_ready", 0, w_ready, 0);
        chk("rst act_ready", 0, act_ready, 0);
        chk("rst sa_w_load", 0, sa_w_load, 0);
        chk("rst sa_act_en", 0, sa_act_en, 0);
        chk("rst out_valid", 0, out_valid, 0);
        chk("rst w_row_idx", 0, w_row_idx, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            run_job(k);
        end

        // Second start during STREAM is ignored; async reset at cycle 5 aborts the job.
        @(posedge clk); #1 start = 1'b1; num_rows = 8'd2;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1 start = 1'b0;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        #1;
        chk("abort w_ready", 5, w_ready, 0);
        chk("abort act_ready", 5, act_ready, 1);
        chk("abort busy", 5, busy, 1);
        rst = 1'b1;
        #1;
        chk("async busy", 5, busy, 0);
        chk("async act_ready", 5, act_ready, 0);
        chk("async sa_act_en", 5, sa_act_en, 0);
        chk("async out_valid", 5, out_valid, 0);
        chk("async w_ready", 5, w_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("post-rst out_valid", c, out_valid, 0);
            chk("post-rst done", c, done, 0);
            chk("post-rst busy", c, busy, 0);
        end
        run_job(0);

        // Start held high through the job and DONE is not queued.
        @(posedge clk); #1 start = 1'b1; num_rows = 8'd0;
        for (int c = 1; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (c == 5) chk("hold done", c, done, 1);
        end
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("hold busy", 6, busy, 0);
        @(posedge clk); @(posedge clk);

`ifdef SA_SEQ_KEEP_WEIGHTS_EN
        // After reset keep_weights cannot skip loading.
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 start = 1'b1; keep_weights = 1'b1; num_rows = 8'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("kw cold w_ready", 1, w_ready, 1);
        repeat (14) @(posedge clk);
        // Weights now resident: job goes straight to STREAM.
        #1 start = 1'b1; num_rows = 8'd1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("kw warm w_ready", 1, w_ready, 0);
        chk("kw warm act_ready", 1, act_ready, 1);
        chk("kw warm sa_act_en", 1, sa_act_en, 3'b001);
        for (int c = 2; c < 12; c++) begin
            @(negedge clk);
            chk("kw warm w_ready", c, w_ready, 0);
        end
        keep_weights = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
